// File: rtl/pie_pkg.sv
// Shared types and constants for the PIE receive frame controller.
// Holds the FSM state encoding and the CRC-5 polynomial/preset.
package pie_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ARMED,
        ST_COLLECT
    } pie_state_e;

    // x^5 + x^3 + 1, with the x^5 term implicit
    localparam logic [4:0] CRC5_POLY   = 5'b01001;
    localparam logic [4:0] CRC5_PRESET = 5'b01001;

    // One serial CRC-5 step: the feedback is the register MSB xor the new bit
    function automatic logic [4:0] crc5_step(
        input logic [4:0] c,
        input logic       b
    );
        logic fb;
        fb = c[4] ^ b;
        return {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/pie_crc5.sv
// Serial CRC-5 engine, one bit per enabled cycle.
// init restarts from the preset and may consume a bit in the same cycle.
module pie_crc5
    import pie_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic       bit_in,
    output logic [4:0] crc
);

    logic [4:0] r_crc;

    // Restart from the preset on init, otherwise fold in each enabled bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc <= CRC5_PRESET;
        end else if (init) begin
            r_crc <= en ? crc5_step(CRC5_PRESET, bit_in) : CRC5_PRESET;
        end else if (en) begin
            r_crc <= crc5_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/pie_rx_frame_ctrl.sv
// PIE frame controller: silence-delimited framing, MSB-first assembly,
// one-entry valid/ready output buffer. Optional CRC-5 check: PIE_CRC5_EN.
module pie_rx_frame_ctrl
    import pie_pkg::*;
#(
    parameter int FRAME_BITS = 16,
    parameter int GAP_CYCLES = 12,
    parameter int GAP_W      = 5
) (
    input  logic                  sclk_3mhz,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  zero_detect,
    input  logic                  one_detect,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_len_err,
    output logic                  sym_err,
    output logic                  overflow,
    output logic                  crc_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    pie_state_e            r_state;
    pie_state_e            w_next_state;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [GAP_W-1:0]      w_gap_next;
    logic [GAP_W-1:0]      w_gap_inc;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CNT_W-1:0]      w_bit_next;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic                  r_frame_valid;
    logic                  r_len_err;
    logic                  r_sym_err;
    logic                  r_ovf;
    logic                  r_crc_err;
    logic                  w_any;
    logic                  w_dbl;
    logic                  w_single;
    logic                  w_shift_en;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_sym;
    logic                  w_crc_bad;

    assign w_any        = zero_detect | one_detect;
    assign w_dbl        = zero_detect & one_detect;
    assign w_single     = zero_detect ^ one_detect;
    assign w_shift_next = {r_shift[FRAME_BITS-2:0], one_detect};

    // Gap counter increments but parks at GAP_CYCLES
    assign w_gap_inc = (r_gap_cnt == GAP_W'(GAP_CYCLES))
                     ? r_gap_cnt
                     : r_gap_cnt + GAP_W'(1);

    // Next-state, counter and event decode
    always_comb begin
        w_next_state = r_state;
        w_gap_next   = r_gap_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_en   = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_sym        = 1'b0;
        if (!enable) begin
            w_next_state = ST_IDLE;
            w_gap_next   = '0;
            w_bit_next   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_SYNC;
                    w_gap_next   = '0;
                end
                ST_SYNC: begin
                    if (w_any) begin
                        w_gap_next = '0;
                    end else begin
                        w_gap_next = w_gap_inc;
                        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                            w_next_state = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_dbl) begin
                        w_sym        = 1'b1;
                        w_next_state = ST_SYNC;
                        w_gap_next   = '0;
                        w_bit_next   = '0;
                    end else if (w_single) begin
                        w_shift_en   = 1'b1;
                        w_next_state = ST_COLLECT;
                        w_gap_next   = '0;
                        w_bit_next   = CNT_W'(1);
                    end else begin
                        w_gap_next = w_gap_inc;
                    end
                end
                ST_COLLECT: begin
                    if (w_dbl) begin
                        w_sym        = 1'b1;
                        w_next_state = ST_SYNC;
                        w_gap_next   = '0;
                        w_bit_next   = '0;
                    end else if (w_single) begin
                        w_shift_en = 1'b1;
                        w_gap_next = '0;
                        if (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            w_complete   = 1'b1;
                            w_next_state = ST_ARMED;
                            w_bit_next   = '0;
                        end else begin
                            w_bit_next = r_bit_cnt + CNT_W'(1);
                        end
                    end else if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        w_timeout    = 1'b1;
                        w_next_state = ST_ARMED;
                        w_bit_next   = '0;
                        w_gap_next   = w_gap_inc;
                    end else begin
                        w_gap_next = w_gap_inc;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

`ifdef PIE_CRC5_EN
    logic       w_crc_init;
    logic       w_crc_en;
    logic [4:0] w_crc;

    // Bit index equals r_bit_cnt; only the payload bits feed the CRC
    assign w_crc_init = w_shift_en && (r_state == ST_ARMED);
    assign w_crc_en   = w_shift_en
                     && (r_bit_cnt < CNT_W'(FRAME_BITS - 5));

    pie_crc5 u_crc5 (
        .clk    (sclk_3mhz),
        .rst_n  (reset_n),
        .init   (w_crc_init),
        .en     (w_crc_en),
        .bit_in (one_detect),
        .crc    (w_crc)
    );

    assign w_crc_bad = (w_shift_next[4:0] != w_crc);
`else
    assign w_crc_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge sclk_3mhz) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Gap counter, bit counter and shift register
    always_ff @(posedge sclk_3mhz) begin
        if (!reset_n) begin
            r_gap_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_gap_cnt <= w_gap_next;
            r_bit_cnt <= w_bit_next;
            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
        end
    end

    // One-entry output buffer with overflow detection
    always_ff @(posedge sclk_3mhz) begin
        if (!reset_n) begin
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_crc_err     <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (w_complete) begin
                if (!r_frame_valid || frame_ready) begin
                    r_frame_data  <= w_shift_next;
                    r_crc_err     <= w_crc_bad;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    // Single-cycle error pulses
    always_ff @(posedge sclk_3mhz) begin
        if (!reset_n) begin
            r_len_err <= 1'b0;
            r_sym_err <= 1'b0;
        end else begin
            r_len_err <= w_timeout;
            r_sym_err <= w_sym;
        end
    end

    assign frame_data    = r_frame_data;
    assign frame_valid   = r_frame_valid;
    assign frame_len_err = r_len_err;
    assign sym_err       = r_sym_err;
    assign overflow      = r_ovf;
    assign crc_err       = r_crc_err;
    assign busy          = (r_state == ST_COLLECT);

endmodule

// File: tb/tb_pie_rx_frame_ctrl.sv
// Testbench for pie_rx_frame_ctrl with randomized frames.
// Define PIE_CRC5_EN to also exercise the CRC-5 check.
module tb_pie_rx_frame_ctrl;

    localparam int FB = 16;
    localparam int GC = 12;
    localparam int GW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          zd = 1'b0;
    logic          od = 1'b0;
    logic          frame_ready = 1'b1;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_len_err;
    logic          sym_err;
    logic          overflow;
    logic          crc_err;
    logic          busy;

    pie_rx_frame_ctrl #(
        .FRAME_BITS (FB),
        .GAP_CYCLES (GC),
        .GAP_W      (GW)
    ) dut (
        .sclk_3mhz     (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .zero_detect   (zd),
        .one_detect    (od),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_len_err (frame_len_err),
        .sym_err       (sym_err),
        .overflow      (overflow),
        .crc_err       (crc_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Observed transfers and event counts
    logic [FB-1:0] rx_q[$];
    logic          rxc_q[$];
    int            n_len, n_sym, n_ovf, n_vcyc, n_hold;
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic [FB-1:0] p_data = '0;

    // Expected deliveries
    logic [FB-1:0] exp_q[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_valid && frame_ready) begin
                rx_q.push_back(frame_data);
                rxc_q.push_back(crc_err);
            end
            if (frame_len_err) n_len++;
            if (sym_err) n_sym++;
            if (overflow) n_ovf++;
            if (frame_valid) n_vcyc++;
            if (p_valid && !p_ready &&
                (frame_data !== p_data || frame_valid !== 1'b1))
                n_hold++;
        end
        p_valid = frame_valid;
        p_ready = frame_ready;
        p_data  = frame_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        zd = 1'b0;
        od = 1'b0;
        repeat (n) tick();
    endtask

    task automatic strobe(input logic b, input logic dbl);
        zd = dbl | ~b;
        od = dbl | b;
        tick();
        zd = 1'b0;
        od = 1'b0;
    endtask

    // Sends the low nb bits of v, MSB first, one strobe every sp cycles
    task automatic send_bits(
        input logic [31:0] v,
        input int          nb,
        input int          sp,
        input bit          rdy_last
    );
        for (int i = nb - 1; i >= 0; i--) begin
            if (rdy_last && i == 0) frame_ready = 1'b1;
            strobe(v[i], 1'b0);
            if (rdy_last && i == 0) frame_ready = 1'b0;
            idle(sp - 1);
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rxc_q.delete();
        exp_q.delete();
        n_len = 0;
        n_sym = 0;
        n_ovf = 0;
        n_vcyc = 0;
        n_hold = 0;
    endtask

    function automatic int rsp();
        return $urandom_range(1, GC);
    endfunction

    task automatic test_reset();
        logic [FB+5:0] obs;
        reset_n = 1'b0;
        enable  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            zd = 1'($urandom);
            od = 1'($urandom);
            tick();
            obs = {frame_data, frame_valid, frame_len_err,
                   sym_err, overflow, crc_err, busy};
            n_checks++;
            if (obs !== '0) begin
                n_errors++;
                $display("FAIL reset_out: got %h want 0", obs);
            end
        end
        reset_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            zd = 1'($urandom);
            od = 1'($urandom);
            tick();
            obs = {frame_data, frame_valid, frame_len_err,
                   sym_err, overflow, crc_err, busy};
            n_checks++;
            if (obs !== '0) begin
                n_errors++;
                $display("FAIL idle_out: got %h want 0", obs);
            end
        end
        idle(1);
    endtask

    task automatic test_nominal();
        logic [FB-1:0] v;
        clear_obs();
        enable = 1'b1;
        frame_ready = 1'b1;
        idle(GC + 3);
        send_bits(32'h0000A5C3, FB, 4, 1'b0);
        idle(4);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 16'hA5C3) begin
            n_errors++;
            $display("FAIL nominal_data: got n=%0d %h want A5C3",
                     rx_q.size(), rx_q.size() ? rx_q[0] : '0);
        end
        n_checks++;
        if (n_vcyc != 1) begin
            n_errors++;
            $display("FAIL nominal_vcyc: got %0d want 1", n_vcyc);
        end
        clear_obs();
        for (int k = 0; k < 5; k++) begin
            v = FB'($urandom);
            exp_q.push_back(v);
            send_bits(32'(v), FB, rsp(), 1'b0);
        end
        idle(3);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL rand_count: got %0d want %0d",
                     rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                n_checks++;
                if (rx_q[k] !== exp_q[k]) begin
                    n_errors++;
                    $display("FAIL rand_data%0d: got %h want %h",
                             k, rx_q[k], exp_q[k]);
                end
`ifndef PIE_CRC5_EN
                n_checks++;
                if (rxc_q[k] !== 1'b0) begin
                    n_errors++;
                    $display("FAIL crc_tied: got %b want 0", rxc_q[k]);
                end
`endif
            end
        end
    endtask

    task automatic test_short_frame();
        int nb;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            nb = (k == 0) ? 9 : $urandom_range(1, FB - 1);
            send_bits($urandom, nb, rsp(), 1'b0);
            idle(GC + 2);
            n_checks++;
            if (n_len != 1 || rx_q.size() != 0) begin
                n_errors++;
                $display("FAIL short_len: got len=%0d rx=%0d want 1 0",
                         n_len, rx_q.size());
            end
            send_bits(32'h00000F0F, FB, rsp(), 1'b0);
            idle(2);
            n_checks++;
            if (rx_q.size() != 1 || rx_q[0] !== 16'h0F0F) begin
                n_errors++;
                $display("FAIL short_next: got n=%0d want 0F0F",
                         rx_q.size());
            end
        end
    endtask

    task automatic test_backpressure();
        clear_obs();
        frame_ready = 1'b0;
        send_bits(32'h00001234, FB, 3, 1'b0);
        send_bits(32'h00005678, FB, 3, 1'b0);
        idle(2);
        n_checks++;
        if (frame_data !== 16'h1234 || frame_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_keep: got %h v=%b want 1234 v=1",
                     frame_data, frame_valid);
        end
        n_checks++;
        if (n_ovf != 1) begin
            n_errors++;
            $display("FAIL bp_ovf: got %0d want 1", n_ovf);
        end
        n_checks++;
        if (n_hold != 0 || rx_q.size() != 0) begin
            n_errors++;
            $display("FAIL bp_hold: got hold=%0d rx=%0d want 0 0",
                     n_hold, rx_q.size());
        end
        frame_ready = 1'b1;
        idle(1);
        frame_ready = 1'b0;
        idle(1);
        clear_obs();
        send_bits(32'h00001234, FB, 3, 1'b0);
        send_bits(32'h00005678, FB, 3, 1'b1);
        idle(1);
        n_checks++;
        if (frame_data !== 16'h5678 || frame_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_same: got %h v=%b want 5678 v=1",
                     frame_data, frame_valid);
        end
        n_checks++;
        if (n_ovf != 0 || rx_q.size() != 1 || rx_q[0] !== 16'h1234) begin
            n_errors++;
            $display("FAIL bp_xfer: got ovf=%0d rx=%0d want 0 1",
                     n_ovf, rx_q.size());
        end
        frame_ready = 1'b1;
        idle(2);
        n_checks++;
        if (rx_q.size() != 2 || rx_q[1] !== 16'h5678 || n_hold != 0) begin
            n_errors++;
            $display("FAIL bp_drain: got rx=%0d hold=%0d want 2 0",
                     rx_q.size(), n_hold);
        end
    endtask

    task automatic test_sym_err();
        logic [FB-1:0] v;
        clear_obs();
        send_bits($urandom, 4, rsp(), 1'b0);
        strobe(1'b0, 1'b1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL sym_busy: got %b want 0", busy);
        end
        idle(3);
        send_bits($urandom, FB, 4, 1'b0);
        idle(2);
        n_checks++;
        if (n_sym != 1 || rx_q.size() != 0 || n_len != 0) begin
            n_errors++;
            $display("FAIL sym_drop: got sym=%0d rx=%0d len=%0d want 1 0 0",
                     n_sym, rx_q.size(), n_len);
        end
        idle(GC);
        v = FB'($urandom);
        send_bits(32'(v), FB, rsp(), 1'b0);
        idle(2);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== v) begin
            n_errors++;
            $display("FAIL sym_next: got n=%0d want %h", rx_q.size(), v);
        end
    endtask

    task automatic test_abort();
        logic [FB-1:0] v;
        clear_obs();
        send_bits($urandom, 8, rsp(), 1'b0);
        enable = 1'b0;
        idle(1);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_busy: got %b want 0", busy);
        end
        enable = 1'b1;
        idle(GC + 3);
        v = FB'($urandom);
        send_bits(32'(v), FB, rsp(), 1'b0);
        idle(2);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== v || n_len != 0) begin
            n_errors++;
            $display("FAIL abort_next: got n=%0d len=%0d want %h",
                     rx_q.size(), n_len, v);
        end
    endtask

`ifdef PIE_CRC5_EN
    // CRC as the remainder of (data*x^5 + preset*x^11) mod x^5+x^3+1
    function automatic logic [4:0] crc_model(input logic [10:0] d);
        logic [15:0] a;
        a = {d, 5'b00000} ^ {5'b01001, 11'b0};
        for (int i = 15; i >= 5; i--)
            if (a[i]) a = a ^ (16'b101001 << (i - 5));
        return a[4:0];
    endfunction

    task automatic test_crc();
        logic [10:0] d;
        logic [15:0] f;
        int          p;
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            d = 11'($urandom);
            f = {d, crc_model(d)};
            send_bits(32'(f), FB, rsp(), 1'b0);
            p = $urandom_range(5, 15);
            f[p] = ~f[p];
            send_bits(32'(f), FB, rsp(), 1'b0);
            idle(2);
            n_checks++;
            if (rx_q.size() != 2 || rxc_q[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL crc_good: got n=%0d want crc_err 0",
                         rx_q.size());
            end
            n_checks++;
            if (rx_q.size() != 2 || rxc_q[1] !== 1'b1 || rx_q[1] !== f) begin
                n_errors++;
                $display("FAIL crc_bad: got n=%0d want %h crc_err 1",
                         rx_q.size(), f);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_short_frame();
        test_backpressure();
        test_sym_err();
        test_abort();
`ifdef PIE_CRC5_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
